// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - 4-state ALU sequencer with 16x16 register file and psr
// Optional immediate operand path is compiled in when ALU_EXEC_CTRL_IMM_EN is defined.
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_rdest,
  input  logic [3:0]  instr_rsrc,
  input  logic        instr_use_imm,
  input  logic        instr_imm_signed,
  input  logic [7:0]  instr_imm,
  output logic [15:0] alu_rdest,
  output logic [15:0] alu_rsrc,
  output logic [4:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  psr,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t      r_state;
  logic [15:0] r_regs [16];
  logic [4:0]  r_op;
  logic [3:0]  r_rdest;
  logic [3:0]  r_rsrc;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [4:0]  r_alu_op;
  logic [15:0] r_result;
  logic [4:0]  r_flags;
  logic        r_done;
  logic        r_illegal;
  logic [4:0]  r_psr;

  logic [15:0] w_opnd_b;
  logic        w_legal;
  logic        w_reg_write;
  logic        w_psr_write;

`ifdef ALU_EXEC_CTRL_IMM_EN
  logic        r_use_imm;
  logic        r_imm_signed;
  logic [7:0]  r_imm;
  logic [15:0] w_imm_ext;

  assign w_imm_ext = {{8{r_imm_signed & r_imm[7]}}, r_imm};
  assign w_opnd_b  = r_use_imm ? w_imm_ext : r_regs[r_rsrc];
`else
  // Immediate fields are accepted on the port but have no effect in this build.
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, instr_use_imm, instr_imm_signed, instr_imm};
  assign w_opnd_b     = r_regs[r_rsrc];
`endif

  assign w_legal     = (r_op <= 5'd9);
  assign w_reg_write = w_legal && (r_op != 5'd2);
  assign w_psr_write = (r_op <= 5'd2);

  assign instr_ready = (r_state == S_IDLE);
  assign alu_rdest   = r_alu_a;
  assign alu_rsrc    = r_alu_b;
  assign alu_opcode  = r_alu_op;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign psr         = r_psr;
  assign dbg_data    = r_regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_op      <= '0;
      r_rdest   <= '0;
      r_rsrc    <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_psr     <= '0;
`ifdef ALU_EXEC_CTRL_IMM_EN
      r_use_imm    <= 1'b0;
      r_imm_signed <= 1'b0;
      r_imm        <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr_op;
            r_rdest <= instr_rdest;
            r_rsrc  <= instr_rsrc;
`ifdef ALU_EXEC_CTRL_IMM_EN
            r_use_imm    <= instr_use_imm;
            r_imm_signed <= instr_imm_signed;
            r_imm        <= instr_imm;
`endif
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Operand registers double as the ALU drive, so they are live only in EXEC.
          r_alu_a  <= r_regs[r_rdest];
          r_alu_b  <= w_opnd_b;
          r_alu_op <= r_op;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_result  <= alu_out;
          r_flags   <= alu_flags;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_alu_op  <= '0;
          r_done    <= 1'b1;
          r_illegal <= !w_legal;
          r_state   <= S_WB;
        end
        S_WB: begin
          if (w_reg_write) r_regs[r_rdest] <= r_result;
          if (w_psr_write) r_psr <= r_flags;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 instr_valid  input  1  requester presents an instruction.
REQ-004 instr_ready  output  1  block can accept an instruction (high only in IDLE).
REQ-005 instr_op  input  5  ALU opcode: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 LSH, 8 RSH, 9 ARSH.
REQ-006 instr_rdest, instr_rsrc  input  4 each  register-file indices for the destination and source operands.
REQ-007 instr_use_imm, instr_imm_signed, instr_imm  input  1/1/8  select an 8-bit immediate in place of the Rsrc value, with sign or zero extension.
REQ-008 alu_rdest, alu_rsrc  output  16 each  operands driven to the ALU.
REQ-009 alu_opcode  output  5  opcode driven to the ALU.
REQ-010 alu_out, alu_flags  input  16/5  ALU result and flags; flags are {N,Z,F,L,C}, with bit 0 = C.
REQ-011 done  output  1  one-cycle pulse when an instruction retires.
REQ-012 illegal  output  1  one-cycle pulse, coincident with done, for an opcode greater than 9.
REQ-013 psr  output  5  processor status flags, in the same bit order as alu_flags.
REQ-014 dbg_addr / dbg_data  input 4 / output 16  combinational read port into the register file.

Function
REQ-015 The block SHALL contain a 16 x 16-bit register file: one write port (internal) and two internal read ports plus the debug read port.
REQ-016 The FSM SHALL have exactly four states: IDLE, READ, EXEC, WB.
REQ-017 State transitions SHALL be:
  - IDLE -> READ on instr_valid & instr_ready;
  - READ -> EXEC;
  - EXEC -> WB;
  - WB -> IDLE.
REQ-018 In IDLE, an instruction SHALL be accepted only when instr_valid is high; all instruction fields SHALL be latched in that same cycle.
REQ-019 In READ, the block SHALL latch regfile[rdest] as operand A, and SHALL latch either regfile[rsrc] or the extended immediate as operand B.
REQ-020 In EXEC, the block SHALL drive alu_rdest=A, alu_rsrc=B and alu_opcode=op, and SHALL register alu_out and alu_flags at the end of that cycle.
REQ-021 alu_rdest, alu_rsrc and alu_opcode SHALL be 0 outside EXEC.
REQ-022 In WB, the block SHALL pulse done high for exactly one cycle.
REQ-023 Latency SHALL be 3 cycles from acceptance to done, with a maximum throughput of one instruction per 4 cycles.
REQ-024 In WB, ops 0, 1 and 3-9 SHALL write the registered result to regfile[rdest].
REQ-025 CMP (op 2) SHALL NOT write the register file.
REQ-026 The psr SHALL be updated with the registered flags only for ADD, SUB and CMP; all other ops SHALL leave psr unchanged.
REQ-027 An op greater than 9 SHALL cause no register write and no psr change, and SHALL assert illegal together with done.
REQ-028 Immediate extension SHALL be:
  - signed: bits [15:8] = imm[7];
  - unsigned: bits [15:8] = 0.
REQ-029 When rdest equals rsrc, both operands SHALL read the same pre-write value.
REQ-030 An instruction presented while the block is not in IDLE SHALL be ignored; the requester must hold instr_valid until instr_ready is high.
REQ-031 dbg_data SHALL reflect register contents as of the last clock edge; a write in WB becomes visible on the following cycle.

Reset
REQ-032 While reset is high at a clock edge:
  - the FSM SHALL go to IDLE;
  - all 16 registers and psr SHALL be cleared to 0;
  - done and illegal SHALL be 0;
  - ALU outputs SHALL be 0.
REQ-033 Reset asserted in READ, EXEC or WB SHALL abort the instruction with no register write, no psr update and no done pulse.
REQ-034 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro ALU_EXEC_CTRL_IMM_EN: when defined, the immediate path of REQ-019 and REQ-028 SHALL be present.
REQ-036 When ALU_EXEC_CTRL_IMM_EN is undefined, instr_use_imm, instr_imm_signed and instr_imm SHALL be ignored and operand B SHALL always be regfile[rsrc]; the ports SHALL remain present.

Verification
REQ-037 Reset, then load r1=5 and r2=3 via ADD-immediate from r0 (IMM_EN defined); then ADD r1,r2 -> done 3 cycles after accept, dbg r1=8, psr C=0.
REQ-038 With r1=0x0003 and r2=0x0005, CMP r1,r2 -> r1 unchanged at 0x0003, psr L=1, N=1.
REQ-039 With r3=0x1234, ADD r3 with a signed immediate of 0xFF -> r3=0x1233, psr C=1.
REQ-040 Op 0x1F on r4=0x00AA -> illegal and done pulse together, r4 still 0x00AA, psr unchanged.
REQ-041 Accept SUB r5,r6, then assert reset in EXEC -> no done pulse, r5=0, instr_ready=1 the cycle after reset deasserts.
REQ-042 Hold instr_valid high continuously with back-to-back XOR instructions -> instr_ready pulses every 4th cycle, and each instruction retires exactly once.
